// File: rtl/gate_analyzer_pkg.sv
// Shared definitions for the gate truth-table analyzer: gate ids, golden
// truth tables indexed as tt[{a,b}], and the analyzer FSM encoding.
package gate_analyzer_pkg;

    localparam logic [2:0] GATE_AND   = 3'd0;
    localparam logic [2:0] GATE_OR    = 3'd1;
    localparam logic [2:0] GATE_NAND  = 3'd2;
    localparam logic [2:0] GATE_NOR   = 3'd3;
    localparam logic [2:0] GATE_XOR   = 3'd4;
    localparam logic [2:0] GATE_XNOR  = 3'd5;
    localparam logic [2:0] GATE_CONST = 3'd6;
    localparam logic [2:0] GATE_OTHER = 3'd7;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_ZERO = 4'b0000;
    localparam logic [3:0] TT_ONE  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_CLASSIFY,
        ST_DONE
    } state_t;

    // Width needed to count 0..range-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned range);
        return (range <= 1) ? 1 : $clog2(range);
    endfunction

endpackage

// File: rtl/gate_classifier.sv
// Maps a 4-bit truth table tt[{a,b}] onto a 2-input gate identifier.
module gate_classifier
    import gate_analyzer_pkg::*;
(
    input  logic [3:0] tt,
    output logic [2:0] gate_id
);

    always_comb begin
        gate_id = GATE_OTHER;
        case (tt)
            TT_AND:          gate_id = GATE_AND;
            TT_OR:           gate_id = GATE_OR;
            TT_NAND:         gate_id = GATE_NAND;
            TT_NOR:          gate_id = GATE_NOR;
            TT_XOR:          gate_id = GATE_XOR;
            TT_XNOR:         gate_id = GATE_XNOR;
            TT_ZERO, TT_ONE: gate_id = GATE_CONST;
            default:         gate_id = GATE_OTHER;
        endcase
    end

endmodule

// File: rtl/gate_truth_table_analyzer.sv
// Sweeps all four {a,b} vectors over a gate under test for PASSES sweeps,
// records the first-pass truth table, checks later passes and classifies it.
module gate_truth_table_analyzer
    import gate_analyzer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic [3:0] truth_table,
    output logic [2:0] gate_id,
    output logic       consistent
);

    localparam int SW = cnt_width(SETTLE_CYCLES);
    localparam int PW = cnt_width(PASSES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);
    localparam state_t        FIRST_STATE = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_DRIVE;

    state_t          state;
    state_t          state_next;
    logic [SW-1:0]   settle_cnt;
    logic [1:0]      vec;
    logic [PW-1:0]   pass_cnt;
    logic [2:0]      class_id;
    logic            start_accept;
    logic            settle_last;
    logic            last_vec;

    assign start_accept = start && (state == ST_IDLE || state == ST_DONE);
    assign settle_last  = (settle_cnt == SETTLE_LAST);
    assign last_vec     = (vec == 2'd3) && (pass_cnt == PASS_LAST);
    assign busy         = (state == ST_DRIVE) || (state == ST_SAMPLE) || (state == ST_CLASSIFY);
    assign done         = (state == ST_DONE);

    gate_classifier u_classifier (
        .tt      (truth_table),
        .gate_id (class_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (start) state_next = FIRST_STATE;
            ST_DRIVE:    if (settle_last) state_next = ST_SAMPLE;
            ST_SAMPLE:   state_next = last_vec ? ST_CLASSIFY : FIRST_STATE;
            ST_CLASSIFY: state_next = ST_DONE;
            ST_DONE:     state_next = start ? FIRST_STATE : ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Settle counter only runs in DRIVE and restarts for every vector.
    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            settle_cnt <= '0;
        end else if (state == ST_DRIVE && !settle_last) begin
            settle_cnt <= settle_cnt + SW'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    // Vector/pass advance; a,b stay on 11 once the final vector has been sampled.
    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            vec      <= 2'd0;
            pass_cnt <= '0;
            a        <= 1'b0;
            b        <= 1'b0;
        end else if (state == ST_SAMPLE && !last_vec) begin
            vec <= vec + 2'd1;
            {a, b} <= vec + 2'd1;
            if (vec == 2'd3) begin
                pass_cnt <= pass_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            truth_table  <= 4'b0000;
            consistent   <= 1'b0;
            gate_id      <= GATE_OTHER;
            result_valid <= 1'b0;
        end else if (start_accept) begin
            truth_table  <= 4'b0000;
            consistent   <= 1'b1;
            result_valid <= 1'b0;
        end else begin
            if (state == ST_SAMPLE) begin
                if (pass_cnt == '0) begin
                    truth_table[vec] <= y;
                end else if (y != truth_table[vec]) begin
                    consistent <= 1'b0;
                end
            end
            if (state == ST_CLASSIFY) begin
                gate_id      <= class_id;
                result_valid <= 1'b1;
            end
        end
    end

endmodule
